// File: rtl/i2c_bit_ctrl.sv
// Bit-level I2C engine: turns one START/STOP/WRITE/READ command into four timed
// open-drain phases, with clock stretching, arbitration-loss detection and bus-busy tracking.
module i2c_bit_ctrl #(
    parameter int DIV_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             cmd_valid_i,
    input  logic [1:0]       cmd_i,
    input  logic             wr_bit_i,
    output logic             cmd_ready_o,
    output logic             done_o,
    output logic             rd_bit_o,
    output logic             arb_lost_o,
    output logic             bus_busy_o,
    input  logic             scl_i,
    input  logic             sda_i,
    output logic             scl_oe_o,
    output logic             sda_oe_o
);

    localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_WRITE = 2'b10;

    typedef enum logic [2:0] {IDLE, PH_A, PH_B, PH_C, PH_D} state_t;

    // Handshake: a command is taken on the rising edge where cmd_valid_i and
    // cmd_ready_o are both 1; ready is high only in IDLE.
    state_t           state;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       cmd_q;
    logic             wr_q;

    logic [SS-1:0] scl_sync;
    logic [SS-1:0] sda_sync;
    logic          scl_s;
    logic          sda_s;
    logic          sda_prev;

    logic masked;
    logic hold;
    logic phase_end;
    logic arb_hit;

    // Returns {scl_oe, sda_oe} for a phase; 1 pulls the line low.
    function automatic logic [1:0] drive(input logic [1:0] c, input logic b, input state_t s);
        logic outer;
        outer = (s == PH_A) || (s == PH_D);
        case (c)
            CMD_START: drive = (s == PH_A) ? 2'b00 : ((s == PH_D) ? 2'b11 : 2'b01);
            CMD_STOP:  drive = (s == PH_A) ? 2'b11 : ((s == PH_B) ? 2'b01 : 2'b00);
            CMD_WRITE: drive = {outer, ~b};
            default:   drive = {outer, 1'b0};
        endcase
    endfunction

    function automatic state_t next_phase(input state_t s);
        case (s)
            PH_A:    next_phase = PH_B;
            PH_B:    next_phase = PH_C;
            PH_C:    next_phase = PH_D;
            default: next_phase = IDLE;
        endcase
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            scl_sync <= '1;
            sda_sync <= '1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SS-2:0], scl_i};
            sda_sync <= {sda_sync[SS-2:0], sda_i};
            sda_prev <= sda_s;
        end
    end

    assign scl_s = scl_sync[SS-1];
    assign sda_s = sda_sync[SS-1];

    // The first SS cycles of a phase still see the previous phase's line level
    // through the synchronizer, so stretching and arbitration ignore them.
    assign masked    = (cnt < DIV_W'(SS));
    assign hold      = !scl_oe_o && !scl_s && !masked;
    assign phase_end = (cnt == div_q) && !hold;
    assign arb_hit   = !masked && !sda_oe_o && !sda_s &&
                       (((cmd_q == CMD_WRITE) && wr_q && ((state == PH_B) || (state == PH_C))) ||
                        ((cmd_q == CMD_STOP) && ((state == PH_C) || (state == PH_D))));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            bus_busy_o <= 1'b0;
        end else if (scl_s && !sda_prev && sda_s) begin
            bus_busy_o <= 1'b0;
        end else if (scl_s && sda_prev && !sda_s) begin
            bus_busy_o <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            cnt         <= '0;
            div_q       <= '0;
            cmd_q       <= CMD_START;
            wr_q        <= 1'b0;
            scl_oe_o    <= 1'b0;
            sda_oe_o    <= 1'b0;
            cmd_ready_o <= 1'b1;
            done_o      <= 1'b0;
            arb_lost_o  <= 1'b0;
            rd_bit_o    <= 1'b0;
        end else begin
            done_o     <= 1'b0;
            arb_lost_o <= 1'b0;
            if (state == IDLE) begin
                if (cmd_valid_i && cmd_ready_o) begin
                    state                <= PH_A;
                    cnt                  <= '0;
                    div_q                <= div_i;
                    cmd_q                <= cmd_i;
                    wr_q                 <= wr_bit_i;
                    cmd_ready_o          <= 1'b0;
                    {scl_oe_o, sda_oe_o} <= drive(cmd_i, wr_bit_i, PH_A);
                end
            end else if (arb_hit) begin
                state       <= IDLE;
                cnt         <= '0;
                scl_oe_o    <= 1'b0;
                sda_oe_o    <= 1'b0;
                cmd_ready_o <= 1'b1;
                arb_lost_o  <= 1'b1;
            end else if (phase_end) begin
                cnt <= '0;
                if ((state == PH_B) && (cmd_q == 2'b11)) begin
                    rd_bit_o <= sda_s;
                end
                if (state == PH_D) begin
                    state       <= IDLE;
                    done_o      <= 1'b1;
                    cmd_ready_o <= 1'b1;
                end else begin
                    state                <= next_phase(state);
                    {scl_oe_o, sda_oe_o} <= drive(cmd_q, wr_q, next_phase(state));
                end
            end else if (!hold) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
